// File: rtl/isqrt_pkg.sv
// Shared constants and types for the inverse-square-root result collector.
package isqrt_pkg;

  localparam int          SIGN_BIT = 31;
  localparam int          EXP_MSB  = 30;
  localparam int          EXP_LSB  = 23;
  localparam logic [7:0]  EXP_ALL1 = 8'hFF;
  localparam int          DATA_W   = 32;
  localparam int          PAIR_W   = 65;

  typedef struct packed {
    logic [DATA_W-1:0] operand;
    logic [DATA_W-1:0] result;
    logic              err;
  } pair_t;

  // A positive normal operand must never yield a negative, Inf/NaN or zero result.
  function automatic logic range_err(input logic [DATA_W-1:0] op,
                                     input logic [DATA_W-1:0] res);
    logic pos_normal;
    logic bad_result;
    pos_normal = !op[SIGN_BIT] && (op[EXP_MSB:EXP_LSB] != 8'h00) &&
                 (op[EXP_MSB:EXP_LSB] != EXP_ALL1);
    bad_result = res[SIGN_BIT] || (res[EXP_MSB:EXP_LSB] == EXP_ALL1) ||
                 (res == '0);
    return pos_normal && bad_result;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word fall-through read; push+pop while full is legal.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_din,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_do_pop;
  logic             w_do_push;

  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_do_pop  = i_pop && !o_empty;
  // A slot freed by a same-cycle pop may be refilled even when full.
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign o_dout    = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_din;
  end

endmodule

// File: rtl/isqrt_result_collector.sv
// Pairs inverse-square-root results with their operands and buffers them for a reader.
// Optional operand/result range check enabled by defining ISQRT_RANGE_CHECK_EN.
module isqrt_result_collector
  import isqrt_pkg::*;
#(
  parameter int TAG_DEPTH  = 16,
  parameter int PAIR_DEPTH = 8,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce,
  input  logic [31:0]       DataIn,
  input  logic [31:0]       DataOut,
  input  logic              DataValid,
  output logic              pair_valid,
  input  logic              pair_ready,
  output logic [31:0]       pair_in,
  output logic [31:0]       pair_out,
  output logic              pair_err,
  output logic [CNT_W-1:0]  pair_count,
  output logic              tag_ovf,
  output logic              orphan,
  output logic              pair_drop
);

  logic [31:0]      w_tag_dout;
  logic             w_tag_full;
  logic             w_tag_empty;
  logic             w_capture;
  logic             w_pair_fire;
  logic             w_pair_rd;
  logic             w_pair_wr;
  logic             w_pair_full;
  logic             w_pair_empty;
  logic             w_err;
  pair_t            w_pair_din;
  pair_t            w_head;

  logic [CNT_W-1:0] r_pair_count;
  logic             r_tag_ovf;
  logic             r_orphan;
  logic             r_pair_drop;

  // DataValid only means something while the core is advancing.
  assign w_capture   = ce && DataValid;
  assign w_pair_fire = w_capture && !w_tag_empty;

  sync_fifo #(.WIDTH(32), .DEPTH(TAG_DEPTH)) u_tag_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (ce),
    .i_pop   (w_pair_fire),
    .i_din   (DataIn),
    .o_dout  (w_tag_dout),
    .o_full  (w_tag_full),
    .o_empty (w_tag_empty)
  );

`ifdef ISQRT_RANGE_CHECK_EN
  assign w_err = range_err(w_tag_dout, DataOut);
`else
  assign w_err = 1'b0;
`endif

  assign w_pair_din = '{operand: w_tag_dout, result: DataOut, err: w_err};
  assign w_pair_rd  = pair_valid && pair_ready;
  assign w_pair_wr  = w_pair_fire && (!w_pair_full || w_pair_rd);

  sync_fifo #(.WIDTH(PAIR_W), .DEPTH(PAIR_DEPTH)) u_pair_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_pair_wr),
    .i_pop   (w_pair_rd),
    .i_din   (w_pair_din),
    .o_dout  (w_head),
    .o_full  (w_pair_full),
    .o_empty (w_pair_empty)
  );

  // Head fields are masked so an empty FIFO presents zeros rather than stale storage.
  assign pair_valid = !w_pair_empty;
  assign pair_in    = pair_valid ? w_head.operand : '0;
  assign pair_out   = pair_valid ? w_head.result  : '0;
  assign pair_err   = pair_valid && w_head.err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pair_count <= '0;
      r_tag_ovf    <= 1'b0;
      r_orphan     <= 1'b0;
      r_pair_drop  <= 1'b0;
    end else begin
      if (w_pair_wr)                              r_pair_count <= r_pair_count + CNT_W'(1);
      if (ce && w_tag_full && !w_pair_fire)       r_tag_ovf    <= 1'b1;
      if (w_capture && w_tag_empty)               r_orphan     <= 1'b1;
      if (w_pair_fire && !w_pair_wr)              r_pair_drop  <= 1'b1;
    end
  end

  assign pair_count = r_pair_count;
  assign tag_ovf    = r_tag_ovf;
  assign orphan     = r_orphan;
  assign pair_drop  = r_pair_drop;

endmodule

// File: tb/tb_isqrt_result_collector.sv
// Directed self-checking bench for isqrt_result_collector (table rows plus corner sequences).
module tb_isqrt_result_collector;

  localparam logic [31:0] MASK = 32'h5A5A5A5A;

  logic        clk = 1'b0;
  logic        rst;
  logic        ce;
  logic [31:0] DataIn;
  logic [31:0] DataOut;
  logic        DataValid;
  logic        pair_valid;
  logic        pair_ready;
  logic [31:0] pair_in;
  logic [31:0] pair_out;
  logic        pair_err;
  logic [15:0] pair_count;
  logic        tag_ovf;
  logic        orphan;
  logic        pair_drop;

  int n_checks = 0;
  int n_pass   = 0;

  typedef logic [84:0] obs_t;

  typedef struct {
    logic        ce;
    logic [31:0] din;
    logic        dv;
    logic [31:0] dout;
    logic        rdy;
    logic        v;
    logic [31:0] ein;
    logic [31:0] eout;
    logic [15:0] cnt;
  } vec_t;

  vec_t tbl [9];

  logic        pv [3];
  logic [31:0] pd [3];

  isqrt_result_collector #(.TAG_DEPTH(16), .PAIR_DEPTH(8), .CNT_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .ce         (ce),
    .DataIn     (DataIn),
    .DataOut    (DataOut),
    .DataValid  (DataValid),
    .pair_valid (pair_valid),
    .pair_ready (pair_ready),
    .pair_in    (pair_in),
    .pair_out   (pair_out),
    .pair_err   (pair_err),
    .pair_count (pair_count),
    .tag_ovf    (tag_ovf),
    .orphan     (orphan),
    .pair_drop  (pair_drop)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic obs_t snap();
    return {pair_valid, pair_in, pair_out, pair_err, pair_count, tag_ovf, orphan, pair_drop};
  endfunction

  function automatic obs_t mk(input logic v, input logic [31:0] in_v, input logic [31:0] out_v,
                              input logic err, input logic [15:0] cnt, input logic [2:0] flags);
    return {v, in_v, out_v, err, cnt, flags};
  endfunction

  function automatic logic exp_err(input logic [31:0] op, input logic [31:0] res);
`ifdef ISQRT_RANGE_CHECK_EN
    return !op[31] && (op[30:23] != 8'h00) && (op[30:23] != 8'hFF) &&
           (res[31] || (res[30:23] == 8'hFF) || (res == 32'h0));
`else
    return 1'b0;
`endif
  endfunction

  task automatic step(input logic c, input logic [31:0] di, input logic dv,
                      input logic [31:0] dout, input logic rdy);
    ce = c; DataIn = di; DataValid = dv; DataOut = dout; pair_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1'b0, '0, 1'b0, '0, 1'b0);
    rst = 1'b0;
  endtask

  // Three-stage core model that only advances when ce is high.
  task automatic core_step(input logic c, input logic [31:0] di, input logic iss);
    ce = c; DataIn = di; DataValid = pv[2]; DataOut = pd[2]; pair_ready = 1'b1;
    @(posedge clk);
    if (c) begin
      pv[2] = pv[1]; pd[2] = pd[1];
      pv[1] = pv[0]; pd[1] = pd[0];
      pv[0] = iss;   pd[0] = di ^ MASK;
    end
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    logic [15:0] cnt7;
    logic [31:0] ops [20];
    int          k;
    int          got;

    rst = 1'b1; ce = 1'b0; DataIn = '0; DataOut = '0; DataValid = 1'b0; pair_ready = 1'b0;

    // Steady stream, ce-gated DataValid, hold-while-not-ready, read+write in one cycle.
    tbl[0] = '{1'b1, 32'h40800000, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        32'h0,        16'd0};
    tbl[1] = '{1'b0, 32'h0,        1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0,        32'h0,        16'd0};
    tbl[2] = '{1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        32'h0,        16'd0};
    tbl[3] = '{1'b1, 32'h40000000, 1'b1, 32'h3F000000, 1'b0, 1'b1, 32'h40800000, 32'h3F000000, 16'd1};
    tbl[4] = '{1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 1'b1, 32'h40800000, 32'h3F000000, 16'd1};
    tbl[5] = '{1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        32'h0,        16'd1};
    tbl[6] = '{1'b1, 32'h41800000, 1'b1, 32'h3F3504F3, 1'b1, 1'b1, 32'h40000000, 32'h3F3504F3, 16'd2};
    tbl[7] = '{1'b1, 32'h3F800000, 1'b1, 32'h3E800000, 1'b1, 1'b1, 32'h41800000, 32'h3E800000, 16'd3};
    tbl[8] = '{1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        32'h0,        16'd3};

    do_reset();
    check("reset_state", snap(), mk(1'b0, '0, '0, 1'b0, 16'd0, 3'b000));

    for (int i = 0; i < 9; i++) begin
      step(tbl[i].ce, tbl[i].din, tbl[i].dv, tbl[i].dout, tbl[i].rdy);
      check($sformatf("table_row%0d", i), snap(),
            mk(tbl[i].v, tbl[i].ein, tbl[i].eout, 1'b0, tbl[i].cnt, 3'b000));
    end

    // Orphan: capture with empty tag FIFO; the co-issued operand is still kept.
    do_reset();
    step(1'b1, 32'h11111111, 1'b1, 32'hCAFEF00D, 1'b0);
    check("orphan_set", snap(), mk(1'b0, '0, '0, 1'b0, 16'd0, 3'b010));
    step(1'b1, 32'h0, 1'b1, 32'h22222222, 1'b0);
    check("orphan_tag_kept", snap(), mk(1'b1, 32'h11111111, 32'h22222222, 1'b0, 16'd1, 3'b010));

    // Overflow: 17 issues into a 16-deep tag FIFO, then 16 captures drained live.
    do_reset();
    for (int i = 0; i < 17; i++) begin
      step(1'b1, 32'h3F800000 + i, 1'b0, '0, 1'b0);
      if (i == 15) check("ovf_not_yet", tag_ovf, 1'b0);
      if (i == 16) check("ovf_on_17th", tag_ovf, 1'b1);
    end
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 32'h0, 1'b1, 32'h40000000 + i, 1'b1);
      check($sformatf("ovf_pair%0d", i), {pair_valid, pair_in, pair_out},
            {1'b1, 32'h3F800000 + i, 32'h40000000 + i});
    end
    check("ovf_final", {pair_count, tag_ovf, orphan, pair_drop}, {16'd16, 3'b100});

    // Backpressure: 9 captures with reader stalled; 9th dropped, head held.
    do_reset();
    for (int i = 0; i < 9; i++) step(1'b1, 32'h3FC00000 + i, 1'b0, '0, 1'b0);
    for (int i = 0; i < 9; i++) begin
      step(1'b1, 32'h0, 1'b1, 32'h3E000000 + i, 1'b0);
      if (i == 7) check("bp_full_no_drop", {pair_count, pair_drop}, {16'd8, 1'b0});
    end
    check("bp_drop", snap(), mk(1'b1, 32'h3FC00000, 32'h3E000000, 1'b0, 16'd8, 3'b001));
    step(1'b0, '0, 1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b0, '0, 1'b0);
    check("bp_head_stable", {pair_valid, pair_in, pair_out}, {1'b1, 32'h3FC00000, 32'h3E000000});
    for (int i = 0; i < 8; i++) begin
      check($sformatf("bp_drain%0d", i), {pair_valid, pair_in, pair_out},
            {1'b1, 32'h3FC00000 + i, 32'h3E000000 + i});
      step(1'b0, '0, 1'b0, '0, 1'b1);
    end
    check("bp_empty_after_drain", pair_valid, 1'b0);

    // ce stall: 20 operands, ce low for cycles 8-11 with DataValid high.
    do_reset();
    for (int s = 0; s < 3; s++) begin pv[s] = 1'b0; pd[s] = '0; end
    k = 0; got = 0; cnt7 = '0;
    for (int i = 0; i < 20; i++) ops[i] = 32'h3F800000 + (i << 8);
    for (int c = 0; c < 60 && got < 20; c++) begin
      logic stall;
      logic iss;
      stall = (c >= 8) && (c <= 11);
      iss   = !stall && (k < 20);
      core_step(!stall, iss ? ops[k] : 32'h0, iss);
      if (iss) k++;
      if (c == 7)  cnt7 = pair_count;
      if (c == 11) check("stall_no_pairs", pair_count, cnt7);
      if (pair_valid) begin
        check($sformatf("stall_pair%0d", got), {pair_in, pair_out}, {ops[got], ops[got] ^ MASK});
        got++;
      end
    end
    check("stall_pair_total", got, 20);
    check("stall_count", pair_count, 16'd20);

    // Range check, then reset mid-stream.
    do_reset();
    step(1'b1, 32'h3F800000, 1'b0, '0, 1'b0);
    step(1'b1, 32'h3F800000, 1'b0, '0, 1'b0);
    step(1'b1, 32'h0, 1'b1, 32'hBF800000, 1'b0);
    check("range_bad", {pair_valid, pair_in, pair_out, pair_err},
          {1'b1, 32'h3F800000, 32'hBF800000, exp_err(32'h3F800000, 32'hBF800000)});
    step(1'b1, 32'h0, 1'b1, 32'h3F800000, 1'b0);
    step(1'b0, '0, 1'b0, '0, 1'b1);
    check("range_good", {pair_valid, pair_in, pair_out, pair_err},
          {1'b1, 32'h3F800000, 32'h3F800000, exp_err(32'h3F800000, 32'h3F800000)});
    step(1'b1, 32'h40400000, 1'b0, '0, 1'b0);
    rst = 1'b1;
    step(1'b1, 32'h40400000, 1'b1, 32'h3F13CD3A, 1'b1);
    check("midrun_reset", snap(), mk(1'b0, '0, '0, 1'b0, 16'd0, 3'b000));
    rst = 1'b0;
    step(1'b1, 32'h0, 1'b1, 32'h12345678, 1'b0);
    check("midrun_tags_gone", snap(), mk(1'b0, '0, '0, 1'b0, 16'd0, 3'b010));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/isqrt_result_collector.md
Name: isqrt_result_collector

Overview:
- Hardware receiving end of the inverse-square-root stream.
- Snoops the operand side (ce, DataIn) and the result side (DataOut, DataValid) of the inverse-square-root core.
- Pairs each result in order with the operand that produced it, and buffers {operand, result} pairs for a downstream reader using valid/ready.
- Replaces the file-dump capture path, so results can be checked on silicon.

Parameters:
TAG_DEPTH, 16, depth of the in-flight operand FIFO; must be a power of 2 and at least the core latency + 1.
PAIR_DEPTH, 8, depth of the output pair FIFO; power of 2.
CNT_W, 16, width of the pair counter.

Ports:
clk  in  1  system clock; all logic on the rising edge.
rst  in  1  synchronous reset, active-high.
ce  in  1  core clock-enable; operand issued / pipeline advances when 1.
DataIn  in  32  operand presented to the core (IEEE-754 single).
DataOut  in  32  core result.
DataValid  in  1  core result valid.
pair_valid  out  1  head pair available.
pair_ready  in  1  reader accepts head pair.
pair_in  out  32  operand of head pair.
pair_out  out  32  result of head pair.
pair_err  out  1  range-error tag of head pair (see Optional Feature).
pair_count  out  CNT_W  pairs accepted into the pair FIFO; wraps to 0 after the all-ones value.
tag_ovf  out  1  sticky: operand issued while the tag FIFO was full.
orphan  out  1  sticky: result arrived while the tag FIFO was empty.
pair_drop  out  1  sticky: pair lost because the pair FIFO was full.

Behaviour:
Reset:
- Both FIFOs emptied.
- pair_valid, pair_err, tag_ovf, orphan, pair_drop = 0; pair_count = 0.
- pair_in and pair_out = 0.

Issue (tag push):
- Every cycle with ce=1 pushes DataIn into the tag FIFO.
- Push when full: operand discarded and tag_ovf set; the FIFO is unchanged.

Capture (tag pop):
- Active on cycles with ce=1 && DataValid=1. DataValid with ce=0 is ignored; the core is frozen.
- Pops the oldest tag and forms the pair {tag, DataOut}.
- Same-cycle push and pop are legal at any occupancy, including full: occupancy is unchanged and no tag_ovf.
- Pop from empty while a push is also active: push discarded as a pair source, orphan set, no pair formed, and the pushed tag is still stored.
- Pop from empty with no push: orphan set, nothing stored.

Pair FIFO:
- A pair formed at the rising edge of cycle N is visible on pair_* at cycle N+1. Latency is 1 cycle; no bypass.
- A pair is written only if the FIFO is not full, or if a read (pair_valid && pair_ready) occurs in the same cycle. Otherwise the pair is dropped and pair_drop set.
- pair_count increments on each successful write.
- pair_in, pair_out and pair_err hold stable while pair_valid=1 and pair_ready=0.

Flags and reset timing:
- Sticky flags clear only on rst.
- rst mid-stream discards all in-flight tags and pairs in the same edge; there is no partial output.

Optional Feature:
Macro: ISQRT_RANGE_CHECK_EN
- Defined: pair_err = 1 when the operand is a positive normal (sign 0, exponent not 0x00 and not 0xFF) and the result is invalid. A result is invalid when its sign bit is 1, its exponent is 0xFF, or it equals 0x00000000. The check is combinational on the capture path and stored with the pair.
- Undefined: pair_err tied 0 and no check logic is built. The port remains so benches are unchanged.

Decomposition:
- Package isqrt_pkg holds:
  - float field constants: SIGN_BIT=31, EXP_MSB=30, EXP_LSB=23, EXP_ALL1=8'hFF;
  - the pair width constant (65).
- One natural sub-module: sync_fifo, parameterised by width and depth, instantiated twice. It has:
  - push/pop/full/empty;
  - simultaneous push+pop when full is legal.
- The collector top holds the sticky flags, pair_count and the range check.

Test Plan:
- Steady stream:
  - Stimulus: ce=1, DataIn=32'h40800000 (4.0); 3 cycles later DataValid with DataOut=32'h3F000000.
  - Response: pair {40800000, 3F000000} appears 1 cycle after capture; pair_count=1; all flags 0.
- ce stall:
  - Stimulus: 20 operands with ce=0 for cycles 8-11; DataValid held high during the stall.
  - Response: the 4 stalled cycles add no tags and no pairs; 20 pairs come out in issue order.
- Backpressure:
  - Stimulus: pair_ready=0 with 9 results captured.
  - Response: PAIR_DEPTH=8 pairs held and stable; the 9th dropped; pair_drop=1; pair_count=8.
- Orphan:
  - Stimulus: after reset, DataValid=1, ce=1 with no prior issue.
  - Response: orphan=1, no pair.
- Overflow:
  - Stimulus: 17 issues with no DataValid.
  - Response: tag_ovf=1 on the 17th; the first 16 results later pair correctly.
- Range check (ISQRT_RANGE_CHECK_EN):
  - Stimulus: operand 3F800000 with result BF800000; then operand 3F800000 with result 3F800000.
  - Response: first pair has pair_err=1, second has 0. Mid-run rst empties everything and pair_valid=0 on the next cycle.
